// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the byte-serial memory controller.
// Contents:
//   state_e        controller FSM states
//   LEN_*          ls_len encodings (number of bytes minus one)
//   IO_SEL_DEFAULT default value of address bits [17:16] that select the I/O space
//   is_io_addr     returns 1 when an address falls in the I/O space
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_e;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

    function automatic logic is_io_addr(input logic [31:0] addr, input logic [1:0] sel);
        return addr[17:16] == sel;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of every non-clock signal between the memory controller, its two requesters
// (instruction fetch and load/store) and the byte-wide RAM / I/O port.
// Signals:
//   mem_din, mem_dout, mem_a, mem_wr   byte-wide RAM port (read data one cycle late)
//   io_buffer_full                      I/O sink back-pressure
//   flush                               cancel an in-flight instruction fetch
//   if_req/if_addr/if_done/if_data      instruction-fetch handshake
//   ls_req/ls_wr/ls_addr/ls_len/ls_wdata/ls_done/ls_rdata  load/store handshake
// Modports:
//   slave   controller view
//   master  requester / memory-system view
interface mem_ctrl_if;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        flush;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [1:0]  ls_len;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    modport slave (
        input  mem_din, io_buffer_full, flush,
        input  if_req, if_addr,
        input  ls_req, ls_wr, ls_addr, ls_len, ls_wdata,
        output mem_dout, mem_a, mem_wr,
        output if_done, if_data,
        output ls_done, ls_rdata
    );

    modport master (
        output mem_din, io_buffer_full, flush,
        output if_req, if_addr,
        output ls_req, ls_wr, ls_addr, ls_len, ls_wdata,
        input  mem_dout, mem_a, mem_wr,
        input  if_done, if_data,
        input  ls_done, ls_rdata
    );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store traffic onto
// a single 8-bit RAM port. A transaction of n bytes presents address base+k in its k-th
// cycle; reads capture the RAM byte one cycle later into a little-endian merge register
// and signal done one cycle after the last capture; writes drive one byte per cycle and
// signal done the cycle after the last byte. Writes to the I/O space stall while the I/O
// sink is full. rdy_in low freezes everything.
// Ports:
//   clk_in   system clock, rising edge
//   rst_in   asynchronous active-high reset
//   rdy_in   global enable
//   bus      mem_ctrl_if.slave (RAM port, fetch and load/store handshakes)
// Parameters:
//   IO_SEL   value of address bits [17:16] that marks an I/O access
module mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;       // cycles spent in the current transaction
    logic [2:0]  last_q, last_d;     // index of the final byte (bytes minus one)
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;       // read byte merge register
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic [31:0] byte_addr;
    logic        addr_phase;
    logic [1:0]  lane;

    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        if_done;
    logic        ls_done;
    logic        ls_rd_done;

    assign byte_addr  = base_q + {29'd0, cnt_q};
    assign addr_phase = (cnt_q <= last_q);
    // The byte captured at count c was addressed at count c-1.
    assign lane       = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        mem_a      = 32'd0;
        mem_dout   = 8'd0;
        mem_wr     = 1'b0;
        if_done    = 1'b0;
        ls_done    = 1'b0;
        ls_rd_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Load/store wins over a simultaneous fetch; flush only blocks fetch.
                if (bus.ls_req) begin
                    state_d = bus.ls_wr ? LS_WR : LS_RD;
                    base_d  = bus.ls_addr;
                    wdata_d = bus.ls_wdata;
                    last_d  = {1'b0, bus.ls_len};
                    cnt_d   = 3'd0;
                    asm_d   = 32'd0;
                end else if (bus.if_req && !bus.flush) begin
                    state_d = IF_RD;
                    base_d  = bus.if_addr;
                    last_d  = {1'b0, LEN_WORD};
                    cnt_d   = 3'd0;
                    asm_d   = 32'd0;
                end
            end

            IF_RD, LS_RD: begin
                if (addr_phase) begin
                    mem_a = byte_addr;
                end
                if (state_q == IF_RD && bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == last_q + 3'd2) begin
                    // Every byte is merged; publish the word for one cycle.
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == IF_RD) begin
                        if_done   = 1'b1;
                        if_data_d = asm_q;
                    end else begin
                        ls_done    = 1'b1;
                        ls_rd_done = 1'b1;
                        ls_rdata_d = asm_q;
                    end
                end else begin
                    if (cnt_q != 3'd0) begin
                        asm_d[{lane, 3'b000} +: 8] = bus.mem_din;
                    end
                    cnt_d = cnt_q + 3'd1;
                end
            end

            LS_WR: begin
                if (addr_phase) begin
                    mem_a    = byte_addr;
                    mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    // A full I/O sink holds the current byte without writing it.
                    if (!(is_io_addr(byte_addr, IO_SEL) && bus.io_buffer_full)) begin
                        mem_wr = 1'b1;
                        cnt_d  = cnt_q + 3'd1;
                    end
                end else begin
                    ls_done = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        if (!rdy_in) begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            last_d     = last_q;
            base_d     = base_q;
            wdata_d    = wdata_q;
            asm_d      = asm_q;
            if_data_d  = if_data_q;
            ls_rdata_d = ls_rdata_q;
            mem_wr     = 1'b0;
            if_done    = 1'b0;
            ls_done    = 1'b0;
            ls_rd_done = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            last_q     <= 3'd0;
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            asm_q      <= 32'd0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.mem_a    = mem_a;
    assign bus.mem_dout = mem_dout;
    assign bus.mem_wr   = mem_wr;
    assign bus.if_done  = if_done;
    assign bus.ls_done  = ls_done;
    // The word is visible during the done pulse and held in the register afterwards.
    assign bus.if_data  = if_done ? asm_q : if_data_q;
    assign bus.ls_rdata = ls_rd_done ? asm_q : ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized transactions checked
// against a transaction-level reference model (expected address/byte streams and done
// timing computed from byte counts, stall and freeze cycles).
module tb_mem_ctrl;
    import riscv_mem_pkg::*;

    logic clk;
    logic rst;
    logic rdy;

    mem_ctrl_if bus ();

    mem_ctrl #(.IO_SEL(IO_SEL_DEFAULT)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  env_ram [logic [31:0]];  // memory seen by the DUT
    logic [7:0]  ref_ram [logic [31:0]];  // memory predicted by the model
    logic [31:0] last_if_data;
    logic [31:0] last_ls_rdata;

    logic [31:0] s_a, s_if_data, s_ls_rdata;
    logic [7:0]  s_dout;
    logic        s_wr, s_if_done, s_ls_done, s_rdy;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        return env_ram.exists(a) ? env_ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : init_byte(a);
    endfunction

    function automatic logic tb_is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample the current cycle at the falling edge, then move to just after the next
    // rising edge. The RAM model is clock-enabled by rdy like the rest of the system.
    task automatic step();
        @(negedge clk);
        s_a        = bus.mem_a;
        s_dout     = bus.mem_dout;
        s_wr       = bus.mem_wr;
        s_if_done  = bus.if_done;
        s_if_data  = bus.if_data;
        s_ls_done  = bus.ls_done;
        s_ls_rdata = bus.ls_rdata;
        s_rdy      = rdy;
        if (s_wr) env_ram[s_a] = s_dout;
        @(posedge clk);
        #1;
        if (s_rdy) bus.mem_din = env_rd(s_a);
    endtask

    // One complete transaction started from IDLE. full_cyc: cycles (from T) with the I/O
    // sink full; rdy is low for cycles [frz_at, frz_at+frz_len) relative to T.
    task automatic run_txn(input bit is_ls, input bit wr, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] wdata,
                           input int full_cyc, input int frz_at, input int frz_len,
                           input string tag);
        int          n;
        int          k;
        int          adv;
        bit          fin;
        bit          exp_done;
        logic [31:0] word;
        logic [31:0] ba;
        logic [31:0] sh;

        n = is_ls ? int'(len) + 1 : 4;
        if (is_ls) begin
            bus.ls_req   = 1'b1;
            bus.ls_wr    = wr;
            bus.ls_addr  = addr;
            bus.ls_len   = len;
            bus.ls_wdata = wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        step();
        chk({tag, "/idle_a"}, s_a, 32'd0);
        chk({tag, "/idle_wr"}, {31'd0, s_wr}, 32'd0);
        chk({tag, "/hold_if"}, s_if_data, last_if_data);
        chk({tag, "/hold_ls"}, s_ls_rdata, last_ls_rdata);

        word = 32'd0;
        for (int j = 0; j < n; j++) begin
            word = word | ({24'd0, ref_rd(addr + 32'(j))} << (8 * j));
        end

        k   = 0;
        adv = 0;
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            rdy                = !(i >= frz_at && i < frz_at + frz_len);
            bus.io_buffer_full = (i < full_cyc);
            step();
            if (is_ls && wr) begin
                chk({tag, "/if_done"}, {31'd0, s_if_done}, 32'd0);
                if (k < n) begin
                    ba = addr + 32'(k);
                    sh = wdata >> (8 * k);
                    chk({tag, "/wa"}, s_a, ba);
                    chk({tag, "/ls_done_early"}, {31'd0, s_ls_done}, 32'd0);
                    if (s_rdy && !(tb_is_io(ba) && bus.io_buffer_full)) begin
                        chk({tag, "/wr"}, {31'd0, s_wr}, 32'd1);
                        chk({tag, "/dout"}, {24'd0, s_dout}, {24'd0, sh[7:0]});
                        ref_ram[ba] = sh[7:0];
                        k++;
                    end else begin
                        chk({tag, "/wr_hold"}, {31'd0, s_wr}, 32'd0);
                    end
                end else begin
                    chk({tag, "/ls_done"}, {31'd0, s_ls_done}, {31'd0, s_rdy});
                    chk({tag, "/wr_end"}, {31'd0, s_wr}, 32'd0);
                    if (s_rdy) fin = 1'b1;
                end
            end else begin
                chk({tag, "/rd_wr"}, {31'd0, s_wr}, 32'd0);
                if (adv < n) chk({tag, "/ra"}, s_a, addr + 32'(adv));
                exp_done = s_rdy && (adv == n + 1);
                if (is_ls) begin
                    chk({tag, "/ls_done"}, {31'd0, s_ls_done}, {31'd0, exp_done});
                    chk({tag, "/if_done"}, {31'd0, s_if_done}, 32'd0);
                    if (exp_done) chk({tag, "/ls_rdata"}, s_ls_rdata, word);
                end else begin
                    chk({tag, "/if_done"}, {31'd0, s_if_done}, {31'd0, exp_done});
                    chk({tag, "/ls_done"}, {31'd0, s_ls_done}, 32'd0);
                    if (exp_done) chk({tag, "/if_data"}, s_if_data, word);
                end
                if (exp_done) fin = 1'b1;
                if (s_rdy) adv++;
            end
        end
        if (!fin) chk({tag, "/timeout"}, 32'd0, 32'd1);

        rdy                = 1'b1;
        bus.io_buffer_full = 1'b0;
        if (is_ls) begin
            bus.ls_req = 1'b0;
            if (!wr) last_ls_rdata = word;
        end else begin
            bus.if_req   = 1'b0;
            last_if_data = word;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rl;
        int          kind;

        rst                = 1'b1;
        rdy                = 1'b1;
        bus.mem_din        = 8'd0;
        bus.io_buffer_full = 1'b0;
        bus.flush          = 1'b0;
        bus.if_req         = 1'b0;
        bus.if_addr        = 32'd0;
        bus.ls_req         = 1'b0;
        bus.ls_wr          = 1'b0;
        bus.ls_addr        = 32'd0;
        bus.ls_len         = 2'd0;
        bus.ls_wdata       = 32'd0;
        last_if_data       = 32'd0;
        last_ls_rdata      = 32'd0;

        // Reset values, with requests pending.
        repeat (2) @(posedge clk);
        #1;
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        bus.ls_wr  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst/mem_a", bus.mem_a, 32'd0);
        chk("rst/mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst/mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rst/if_done", {31'd0, bus.if_done}, 32'd0);
        chk("rst/ls_done", {31'd0, bus.ls_done}, 32'd0);
        chk("rst/if_data", bus.if_data, 32'd0);
        chk("rst/ls_rdata", bus.ls_rdata, 32'd0);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        bus.ls_wr  = 1'b0;
        rst        = 1'b0;
        step();

        // Fetch of 13 00 00 00 at 0x100.
        env_ram[32'h100] = 8'h13;  ref_ram[32'h100] = 8'h13;
        env_ram[32'h101] = 8'h00;  ref_ram[32'h101] = 8'h00;
        env_ram[32'h102] = 8'h00;  ref_ram[32'h102] = 8'h00;
        env_ram[32'h103] = 8'h00;  ref_ram[32'h103] = 8'h00;
        run_txn(1'b0, 1'b0, 32'h100, LEN_WORD, 32'd0, 0, 99, 0, "fetch100");
        chk("fetch100/word", last_if_data, 32'h0000_0013);

        // Simultaneous fetch and load: load first, fetch then starts from IDLE.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        run_txn(1'b1, 1'b0, 32'h200, LEN_WORD, 32'd0, 0, 99, 0, "both_ls");
        run_txn(1'b0, 1'b0, 32'h600, LEN_WORD, 32'd0, 0, 99, 0, "both_if");

        // Half store straddling 0x1FFFF/0x20000.
        run_txn(1'b1, 1'b1, 32'h1FFFF, LEN_HALF, 32'h0000_BEEF, 0, 99, 0, "st_half");
        chk("st_half/lo", {24'd0, env_rd(32'h1FFFF)}, 32'h0000_00EF);
        chk("st_half/hi", {24'd0, env_rd(32'h20000)}, 32'h0000_00BE);

        // I/O byte write blocked for 3 cycles.
        run_txn(1'b1, 1'b1, 32'h30000, LEN_BYTE, 32'h0000_005A, 3, 99, 0, "io_wr");

        // Load readback of the half store, zero-extended.
        run_txn(1'b1, 1'b0, 32'h1FFFF, LEN_HALF, 32'd0, 0, 99, 0, "ld_half");
        chk("ld_half/word", last_ls_rdata, 32'h0000_BEEF);

        // Freeze in the middle of a fetch and of a store.
        run_txn(1'b0, 1'b0, 32'h840, LEN_WORD, 32'd0, 0, 2, 2, "frz_if");
        run_txn(1'b1, 1'b1, 32'h900, LEN_WORD, 32'h1234_5678, 0, 1, 2, "frz_st");

        // Flush at T+2 of a fetch.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        step();
        step();
        chk("flush/aT", s_a, 32'h400);
        step();
        chk("flush/aT1", s_a, 32'h401);
        bus.flush = 1'b1;
        step();
        chk("flush/aT2", s_a, 32'h402);
        chk("flush/done_T2", {31'd0, s_if_done}, 32'd0);
        bus.flush  = 1'b0;
        bus.if_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("flush/idle_a", s_a, 32'd0);
            chk("flush/no_done", {31'd0, s_if_done}, 32'd0);
            chk("flush/if_data", s_if_data, last_if_data);
        end

        // Flush held in IDLE blocks fetch start but not load/store.
        bus.flush   = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h700;
        step();
        chk("fl_idle/a0", s_a, 32'd0);
        step();
        chk("fl_idle/a1", s_a, 32'd0);
        bus.if_req = 1'b0;
        run_txn(1'b1, 1'b0, 32'h720, LEN_HALF, 32'd0, 0, 99, 0, "fl_ls");
        bus.flush = 1'b0;

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 2));
            ra   = {14'd0, 18'($urandom)};
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFD;
            case ($urandom_range(0, 2))
                0:       rl = LEN_BYTE;
                1:       rl = LEN_HALF;
                default: rl = LEN_WORD;
            endcase
            run_txn(kind != 0, kind == 2, ra, rl, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 2)), $sformatf("rnd%0d", t));
        end

        // Reset in the middle of a word store.
        bus.ls_req   = 1'b1;
        bus.ls_wr    = 1'b1;
        bus.ls_addr  = 32'h500;
        bus.ls_len   = LEN_WORD;
        bus.ls_wdata = 32'hCAFE_F00D;
        step();
        step();
        chk("rst_mid/wr0", {31'd0, s_wr}, 32'd1);
        chk("rst_mid/d0", {24'd0, s_dout}, 32'h0000_000D);
        ref_ram[32'h500] = 8'h0D;
        step();
        chk("rst_mid/a1", s_a, 32'h501);
        ref_ram[32'h501] = 8'hF0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid/mem_a", bus.mem_a, 32'd0);
        chk("rst_mid/mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_mid/mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rst_mid/ls_done", {31'd0, bus.ls_done}, 32'd0);
        chk("rst_mid/if_data", bus.if_data, 32'd0);
        chk("rst_mid/ls_rdata", bus.ls_rdata, 32'd0);
        bus.ls_req    = 1'b0;
        last_if_data  = 32'd0;
        last_ls_rdata = 32'd0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_mid/after_wr", {31'd0, s_wr}, 32'd0);
            chk("rst_mid/after_done", {31'd0, s_ls_done}, 32'd0);
            chk("rst_mid/after_a", s_a, 32'd0);
        end
        chk("rst_mid/byte2", {24'd0, env_rd(32'h502)}, {24'd0, init_byte(32'h502)});

        // Memory after reset still serves reads, including the partial store.
        run_txn(1'b1, 1'b0, 32'h500, LEN_WORD, 32'd0, 0, 99, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
